// File: rtl/regfile_mp_if.sv
// Bus bundle for regfile_mp: read ports, write ports, reservation request and init status.
interface regfile_mp_if #(
  parameter int XLEN  = 64,
  parameter int DEPTH = 32,
  parameter int NRD   = 2,
  parameter int NWR   = 2
);
  localparam int AW = $clog2(DEPTH);

  logic [NRD-1:0]      rd_en;
  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0]      rd_busy;
  logic [NWR-1:0]      wr_en;
  logic [NWR*AW-1:0]   wr_addr;
  logic [NWR*XLEN-1:0] wr_data;
  logic                rsv_en;
  logic [AW-1:0]       rsv_addr;
  logic                init_done;

  modport master (output rd_en, rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
                  input  rd_data, rd_busy, init_done);
  modport slave  (input  rd_en, rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
                  output rd_data, rd_busy, init_done);
endinterface

// File: rtl/regfile_mp.sv
// Multi-port register file with same-cycle write bypass, pending-write scoreboard
// and a post-reset clear sequencer.
module regfile_mp_rd_lane #(
   parameter int XLEN = 64,
   parameter int AW   = 5,
   parameter int NWR  = 2
) (
   input  logic              run,
   input  logic              en,
   input  logic [AW-1:0]     addr,
   input  logic [XLEN-1:0]   arr_data,
   input  logic              arr_busy,
   input  logic [NWR-1:0]    wr_en,
   input  logic [NWR*AW-1:0] wr_addr,
   input  logic [NWR*XLEN-1:0] wr_data,
   output logic [XLEN-1:0]   data,
   output logic              busy
);
   logic            hit;
   logic [XLEN-1:0] byp;

   // Later ports overwrite earlier matches, so the highest-index writer wins.
   always_comb begin
      hit = 1'b0;
      byp = arr_data;
      for (int j = 0; j < NWR; j++) begin
         if (wr_en[j] && wr_addr[j*AW +: AW] == addr) begin
            hit = 1'b1;
            byp = wr_data[j*XLEN +: XLEN];
         end
      end
      data = '0;
      busy = 1'b0;
      if (run && en && addr != '0) begin
         data = byp;
         busy = arr_busy & ~hit;
      end
   end
endmodule

module regfile_mp #(
   parameter int XLEN  = 64,
   parameter int DEPTH = 32,
   parameter int NRD   = 2,
   parameter int NWR   = 2
) (
   input  logic          sys_clk,
   input  logic          rstn,
   regfile_mp_if.slave   bus
);
   localparam int AW = $clog2(DEPTH);

   typedef enum logic {INIT, RUN} state_t;

   state_t            state, state_nxt;
   logic [AW-1:0]     clr_cnt;
   logic [XLEN-1:0]   mem [DEPTH];
   logic [DEPTH-1:0]  sb, sb_nxt;
   logic              run;

   assign run           = (state == RUN);
   assign bus.init_done = run;

   always_ff @(posedge sys_clk) begin
      if (!rstn) state <= INIT;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (state == INIT && clr_cnt == AW'(DEPTH-1)) state_nxt = RUN;
   end

   always_ff @(posedge sys_clk) begin
      if (!rstn)              clr_cnt <= '0;
      else if (state == INIT) clr_cnt <= clr_cnt + 1'b1;
   end

   // Storage has no reset of its own; the INIT sweep clears it instead.
   always_ff @(posedge sys_clk) begin
      if (rstn) begin
         if (state == INIT) begin
            mem[clr_cnt] <= '0;
         end else begin
            for (int j = 0; j < NWR; j++) begin
               if (bus.wr_en[j] && bus.wr_addr[j*AW +: AW] != '0)
                  mem[bus.wr_addr[j*AW +: AW]] <= bus.wr_data[j*XLEN +: XLEN];
            end
         end
      end
   end

   // Retiring writes clear first so a same-cycle reservation takes precedence.
   always_comb begin
      sb_nxt = sb;
      for (int j = 0; j < NWR; j++) begin
         if (bus.wr_en[j] && bus.wr_addr[j*AW +: AW] != '0)
            sb_nxt[bus.wr_addr[j*AW +: AW]] = 1'b0;
      end
      if (bus.rsv_en && bus.rsv_addr != '0) sb_nxt[bus.rsv_addr] = 1'b1;
   end

   always_ff @(posedge sys_clk) begin
      if (!rstn)    sb <= '0;
      else if (run) sb <= sb_nxt;
   end

   for (genvar i = 0; i < NRD; i++) begin : g_rd
      regfile_mp_rd_lane #(.XLEN(XLEN), .AW(AW), .NWR(NWR)) u_lane (
         .run      (run),
         .en       (bus.rd_en[i]),
         .addr     (bus.rd_addr[i*AW +: AW]),
         .arr_data (mem[bus.rd_addr[i*AW +: AW]]),
         .arr_busy (sb[bus.rd_addr[i*AW +: AW]]),
         .wr_en    (bus.wr_en),
         .wr_addr  (bus.wr_addr),
         .wr_data  (bus.wr_data),
         .data     (bus.rd_data[i*XLEN +: XLEN]),
         .busy     (bus.rd_busy[i])
      );
   end
endmodule

// File: tb/tb_regfile_mp.sv
// Directed scoreboard bench for regfile_mp: a default 64x32 2R/2W instance and a
// 32x16 3R/1W instance share clock and reset.
module tb_regfile_mp;
   logic clk = 1'b0;
   logic rstn = 1'b0;
   always #5 clk = ~clk;

   regfile_mp_if #(.XLEN(64), .DEPTH(32), .NRD(2), .NWR(2)) ia ();
   regfile_mp_if #(.XLEN(32), .DEPTH(16), .NRD(3), .NWR(1)) ib ();

   regfile_mp #(.XLEN(64), .DEPTH(32), .NRD(2), .NWR(2)) dut_a (.sys_clk(clk), .rstn(rstn), .bus(ia.slave));
   regfile_mp #(.XLEN(32), .DEPTH(16), .NRD(3), .NWR(1)) dut_b (.sys_clk(clk), .rstn(rstn), .bus(ib.slave));

   typedef struct {
      string       tag;
      bit          b;
      int          port;
      logic [63:0] data;
      logic        busy;
   } exp_t;

   exp_t q[$];
   int checks = 0;
   int failures = 0;

   task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic expect_rd(string tag, bit b, int port, logic [63:0] d, logic busy);
      exp_t e;
      e.tag = tag; e.b = b; e.port = port; e.data = d; e.busy = busy;
      q.push_back(e);
   endtask

   task automatic check_q();
      exp_t e;
      logic [63:0] od;
      logic ob;
      while (q.size() > 0) begin
         e = q.pop_front();
         if (!e.b) begin
            od = ia.rd_data[e.port*64 +: 64];
            ob = ia.rd_busy[e.port];
         end else begin
            od = {32'b0, ib.rd_data[e.port*32 +: 32]};
            ob = ib.rd_busy[e.port];
         end
         chk({e.tag, "_data"}, od, e.data);
         chk({e.tag, "_busy"}, {63'b0, ob}, {63'b0, e.busy});
      end
   endtask

   task automatic idle();
      ia.rd_en = '0; ia.wr_en = '0; ia.rsv_en = 1'b0;
      ib.rd_en = '0; ib.wr_en = '0; ib.rsv_en = 1'b0;
   endtask

   task automatic rd_a(int p, int addr);
      ia.rd_en[p] = 1'b1; ia.rd_addr[p*5 +: 5] = addr[4:0];
   endtask
   task automatic wr_a(int p, int addr, logic [63:0] d);
      ia.wr_en[p] = 1'b1; ia.wr_addr[p*5 +: 5] = addr[4:0]; ia.wr_data[p*64 +: 64] = d;
   endtask
   task automatic rd_b(int p, int addr);
      ib.rd_en[p] = 1'b1; ib.rd_addr[p*4 +: 4] = addr[3:0];
   endtask
   task automatic wr_b(int addr, logic [31:0] d);
      ib.wr_en[0] = 1'b1; ib.wr_addr[3:0] = addr[3:0]; ib.wr_data[31:0] = d;
   endtask

   // Check on the falling edge, then step to just after the next rising edge.
   task automatic cyc();
      @(negedge clk);
      check_q();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int rec_a, rec_b, n;
      ia.rd_addr = '0; ia.wr_addr = '0; ia.wr_data = '0; ia.rsv_addr = '0;
      ib.rd_addr = '0; ib.wr_addr = '0; ib.wr_data = '0; ib.rsv_addr = '0;
      idle();

      // Reset held for two edges
      rd_a(0, 5); rd_a(1, 0); rd_b(2, 3);
      repeat (2) @(posedge clk);
      #1;
      chk("rst_init_done_a", {63'b0, ia.init_done}, 64'd0);
      chk("rst_init_done_b", {63'b0, ib.init_done}, 64'd0);
      expect_rd("rst_a0", 0, 0, 64'd0, 1'b0);
      expect_rd("rst_b2", 1, 2, 64'd0, 1'b0);
      cyc();

      // Release and count edges to init_done; writes during INIT must be dropped
      rstn = 1'b1;
      rec_a = 0; rec_b = 0;
      wr_a(0, 6, 64'hFF); rsv_en_a: ia.rsv_en = 1'b1; ia.rsv_addr = 5'd6;
      rd_a(1, 6);
      for (int e = 1; e <= 40; e++) begin
         @(posedge clk);
         #1;
         if (rec_a == 0 && ia.init_done) rec_a = e;
         if (rec_b == 0 && ib.init_done) rec_b = e;
         if (e == 10) begin
            expect_rd("init_rd_a1", 0, 1, 64'd0, 1'b0);
            check_q();
         end
         if (e == 30) idle();
      end
      chk("init_edges_a", 64'(rec_a), 64'd32);
      chk("init_edges_b", 64'(rec_b), 64'd16);

      // Every entry reads back zero after the clear sweep
      for (int a = 0; a < 32; a++) begin
         idle();
         rd_a(0, a); rd_a(1, a);
         expect_rd("clr_a0", 0, 0, 64'd0, 1'b0);
         expect_rd("clr_a1", 0, 1, 64'd0, 1'b0);
         if (a < 16) begin
            rd_b(2, a);
            expect_rd("clr_b2", 1, 2, 64'd0, 1'b0);
         end
         cyc();
      end

      // Basic write then read on the other port
      idle(); wr_a(0, 5, 64'hDEAD_BEEF_0000_0001); cyc();
      idle(); rd_a(1, 5); expect_rd("basic_x5", 0, 1, 64'hDEAD_BEEF_0000_0001, 1'b0); cyc();

      // x0 is hardwired to zero
      idle(); wr_a(0, 0, 64'h1234); rd_a(1, 0); expect_rd("x0_same", 0, 1, 64'd0, 1'b0); cyc();
      idle(); rd_a(1, 0); expect_rd("x0_next", 0, 1, 64'd0, 1'b0); cyc();

      // Same-address writes: higher port wins, in bypass and in the array
      idle(); wr_a(0, 7, 64'h11); wr_a(1, 7, 64'h22); rd_a(0, 7);
      expect_rd("prio_byp", 0, 0, 64'h22, 1'b0); cyc();
      idle(); rd_a(0, 7); expect_rd("prio_arr", 0, 0, 64'h22, 1'b0); cyc();

      // Scoreboard
      idle(); ia.rsv_en = 1'b1; ia.rsv_addr = 5'd9; rd_a(0, 9);
      expect_rd("rsv_same", 0, 0, 64'd0, 1'b0); cyc();
      idle(); rd_a(0, 9); expect_rd("rsv_next", 0, 0, 64'd0, 1'b1); cyc();
      idle(); ia.rd_addr[4:0] = 5'd9; expect_rd("rsv_rden0", 0, 0, 64'd0, 1'b0); cyc();
      idle(); wr_a(0, 9, 64'h5); rd_a(1, 9); expect_rd("sb_wr_byp", 0, 1, 64'h5, 1'b0); cyc();
      idle(); rd_a(1, 9); expect_rd("sb_wr_after", 0, 1, 64'h5, 1'b0); cyc();
      idle(); ia.rsv_en = 1'b1; ia.rsv_addr = 5'd9; wr_a(1, 9, 64'h6); rd_a(0, 9);
      expect_rd("sb_setclr_same", 0, 0, 64'h6, 1'b0); cyc();
      idle(); rd_a(0, 9); expect_rd("sb_set_wins", 0, 0, 64'h6, 1'b1); cyc();

      // Reset mid-operation
      idle(); wr_a(0, 3, 64'hAB); ia.rsv_en = 1'b1; ia.rsv_addr = 5'd4; cyc();
      idle(); rd_a(0, 3); rd_a(1, 4);
      expect_rd("pre_rst_x3", 0, 0, 64'hAB, 1'b0);
      expect_rd("pre_rst_x4", 0, 1, 64'd0, 1'b1); cyc();
      idle(); rstn = 1'b0; wr_a(0, 8, 64'h77); cyc();
      rstn = 1'b1;
      chk("mid_rst_init_done", {63'b0, ia.init_done}, 64'd0);
      idle(); wr_a(0, 6, 64'h99);
      n = 0;
      while (!ia.init_done && n < 40) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("mid_rst_edges", 64'(n), 64'd32);
      idle(); rd_a(0, 3); rd_a(1, 4);
      expect_rd("post_rst_x3", 0, 0, 64'd0, 1'b0);
      expect_rd("post_rst_x4", 0, 1, 64'd0, 1'b0); cyc();
      idle(); rd_a(0, 6); rd_a(1, 8);
      expect_rd("post_rst_x6", 0, 0, 64'd0, 1'b0);
      expect_rd("post_rst_x8", 0, 1, 64'd0, 1'b0); cyc();

      // Narrow 3R/1W instance
      chk("b_init_done", {63'b0, ib.init_done}, 64'd1);
      idle(); wr_b(5, 32'hDEAD_BEEF); cyc();
      idle(); rd_b(2, 5); rd_b(0, 0);
      expect_rd("b_x5", 1, 2, 64'hDEAD_BEEF, 1'b0);
      expect_rd("b_x0", 1, 0, 64'd0, 1'b0); cyc();
      idle(); wr_b(0, 32'h1234); rd_b(1, 0); expect_rd("b_x0_wr", 1, 1, 64'd0, 1'b0); cyc();
      idle(); wr_b(7, 32'h22); rd_b(2, 7); rd_b(1, 5);
      expect_rd("b_byp", 1, 2, 64'h22, 1'b0);
      expect_rd("b_other", 1, 1, 64'hDEAD_BEEF, 1'b0); cyc();
      idle(); rd_b(0, 7); expect_rd("b_arr", 1, 0, 64'h22, 1'b0); cyc();
      idle(); ib.rsv_en = 1'b1; ib.rsv_addr = 4'd9; cyc();
      idle(); rd_b(1, 9); expect_rd("b_rsv", 1, 1, 64'd0, 1'b1); cyc();
      idle(); wr_b(9, 32'h5); rd_b(1, 9); expect_rd("b_rsv_clr", 1, 1, 64'h5, 1'b0); cyc();
      idle(); rd_b(1, 9); expect_rd("b_rsv_after", 1, 1, 64'h5, 1'b0); cyc();
      idle(); ib.rsv_en = 1'b1; ib.rsv_addr = 4'd9; wr_b(9, 32'h6); cyc();
      idle(); rd_b(0, 9); expect_rd("b_set_wins", 1, 0, 64'h6, 1'b1); cyc();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
